// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing source.
// Produces active-region sync pulses (o_HSync/o_VSync) for downstream count
// recovery, true VGA connector syncs with porches, and the matching column/row
// counts. Every output is a register computed from the *next* counts, so all
// outputs agree with o_Col_Count/o_Row_Count on the same edge (zero lag).
// An IDLE/RUN/DRAIN controller guarantees a stop only ever happens on a frame
// boundary: dropping i_Enable lets the current frame finish before idling.
module vga_sync_gen #(
   parameter int TOTAL_COLS      = 800,
   parameter int TOTAL_ROWS      = 525,
   parameter int ACTIVE_COLS     = 640,
   parameter int ACTIVE_ROWS     = 480,
   parameter int H_FRONT_PORCH   = 16,
   parameter int H_SYNC_WIDTH    = 96,
   parameter int V_FRONT_PORCH   = 10,
   parameter int V_SYNC_WIDTH    = 2,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Enable,
   output logic       o_HSync,
   output logic       o_VSync,
   output logic       o_HSync_Pin,
   output logic       o_VSync_Pin,
   output logic [9:0] o_Col_Count,
   output logic [9:0] o_Row_Count,
   output logic       o_Active,
   output logic       o_Line_Start,
   output logic       o_Frame_Start,
   output logic       o_Running
);

   // Timing boundaries, 11 bits wide so a window ending at 1024 still fits.
   localparam logic [10:0] LAST_COL  = 11'(TOTAL_COLS - 1);
   localparam logic [10:0] LAST_ROW  = 11'(TOTAL_ROWS - 1);
   localparam logic [10:0] ACT_COLS  = 11'(ACTIVE_COLS);
   localparam logic [10:0] ACT_ROWS  = 11'(ACTIVE_ROWS);
   localparam logic [10:0] HS_START  = 11'(ACTIVE_COLS + H_FRONT_PORCH);
   localparam logic [10:0] HS_END    = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
   localparam logic [10:0] VS_START  = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
   localparam logic [10:0] VS_END    = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);
   // Level a connector sync pin rests at when not asserted.
   localparam logic        PIN_IDLE  = (SYNC_ACTIVE_LOW != 0);

   // Reject timing sets that cannot be represented or do not fit in a line/frame.
   if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h
      $error("vga_sync_gen: horizontal active+porch+sync exceeds TOTAL_COLS");
   end
   if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v
      $error("vga_sync_gen: vertical active+porch+sync exceeds TOTAL_ROWS");
   end
   if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_size
      $error("vga_sync_gen: TOTAL_COLS/TOTAL_ROWS must not exceed 1024");
   end

   // IDLE: parked at (0,0). RUN: counting with enable high.
   // DRAIN: counting with enable low; idles only after the frame's last pixel.
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t      state, state_next;
   logic [10:0] col_cur, row_cur;
   logic [10:0] col_next, row_next;
   logic        run_next;

   assign col_cur = {1'b0, o_Col_Count};
   assign row_cur = {1'b0, o_Row_Count};

   // Next-state and next-count decode; outputs are derived from these values.
   always_comb begin
      state_next = state;
      col_next   = col_cur;
      row_next   = row_cur;
      case (state)
         IDLE: begin
            col_next = '0;
            row_next = '0;
            if (i_Enable) state_next = RUN;
         end
         RUN, DRAIN: begin
            if (col_cur == LAST_COL) begin
               col_next = '0;
               row_next = (row_cur == LAST_ROW) ? 11'd0 : row_cur + 11'd1;
            end else begin
               col_next = col_cur + 11'd1;
            end
            state_next = i_Enable ? RUN : DRAIN;
            if (state == DRAIN && !i_Enable &&
                col_cur == LAST_COL && row_cur == LAST_ROW) begin
               state_next = IDLE;
               col_next   = '0;
               row_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
            col_next   = '0;
            row_next   = '0;
         end
      endcase
      run_next = (state_next != IDLE);
   end

   // State, counts and every output register update together on one edge.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state         <= IDLE;
         o_Col_Count   <= '0;
         o_Row_Count   <= '0;
         o_HSync       <= 1'b0;
         o_VSync       <= 1'b0;
         o_Active      <= 1'b0;
         o_Line_Start  <= 1'b0;
         o_Frame_Start <= 1'b0;
         o_Running     <= 1'b0;
         o_HSync_Pin   <= PIN_IDLE;
         o_VSync_Pin   <= PIN_IDLE;
      end else begin
         state         <= state_next;
         o_Col_Count   <= col_next[9:0];
         o_Row_Count   <= row_next[9:0];
         o_HSync       <= run_next && (col_next < ACT_COLS);
         o_VSync       <= run_next && (row_next < ACT_ROWS);
         o_Active      <= run_next && (col_next < ACT_COLS) && (row_next < ACT_ROWS);
         o_Line_Start  <= run_next && (col_next == 11'd0);
         o_Frame_Start <= run_next && (col_next == 11'd0) && (row_next == 11'd0);
         o_Running     <= run_next;
         o_HSync_Pin   <= (run_next && col_next >= HS_START && col_next < HS_END)
                          ? ~PIN_IDLE : PIN_IDLE;
         o_VSync_Pin   <= (run_next && row_next >= VS_START && row_next < VS_END)
                          ? ~PIN_IDLE : PIN_IDLE;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: two small-geometry instances (active-high and active-low
// pins) driven by one randomized enable/reset stream. A frame-position model
// predicts every output each cycle; a monitor compares after each edge.
module tb_vga_sync_gen;

   // Instance A: 10x8, active 6x4, FP 1/1, SW 2/1, pins active-high.
   // Instance B: 20x12, active 12x6, FP 3/2, SW 4/3, pins active-low.
   int P_TC [2] = '{10, 20};
   int P_TR [2] = '{8, 12};
   int P_AC [2] = '{6, 12};
   int P_AR [2] = '{4, 6};
   int P_HFP[2] = '{1, 3};
   int P_HSW[2] = '{2, 4};
   int P_VFP[2] = '{1, 2};
   int P_VSW[2] = '{1, 3};
   int P_SAL[2] = '{0, 1};

   logic i_Clk, i_Reset, i_Enable;

   logic       a_hs, a_vs, a_hp, a_vp, a_act, a_ls, a_fs, a_run;
   logic [9:0] a_col, a_row;
   logic       b_hs, b_vs, b_hp, b_vp, b_act, b_ls, b_fs, b_run;
   logic [9:0] b_col, b_row;
   logic [27:0] act_a, act_b;

   assign act_a = {a_col, a_row, a_hs, a_vs, a_hp, a_vp, a_act, a_ls, a_fs, a_run};
   assign act_b = {b_col, b_row, b_hs, b_vs, b_hp, b_vp, b_act, b_ls, b_fs, b_run};

   vga_sync_gen #(.TOTAL_COLS(10), .TOTAL_ROWS(8), .ACTIVE_COLS(6), .ACTIVE_ROWS(4),
                  .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .V_FRONT_PORCH(1),
                  .V_SYNC_WIDTH(1), .SYNC_ACTIVE_LOW(0)) u_a (
      .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Enable(i_Enable),
      .o_HSync(a_hs), .o_VSync(a_vs), .o_HSync_Pin(a_hp), .o_VSync_Pin(a_vp),
      .o_Col_Count(a_col), .o_Row_Count(a_row), .o_Active(a_act),
      .o_Line_Start(a_ls), .o_Frame_Start(a_fs), .o_Running(a_run));

   vga_sync_gen #(.TOTAL_COLS(20), .TOTAL_ROWS(12), .ACTIVE_COLS(12), .ACTIVE_ROWS(6),
                  .H_FRONT_PORCH(3), .H_SYNC_WIDTH(4), .V_FRONT_PORCH(2),
                  .V_SYNC_WIDTH(3), .SYNC_ACTIVE_LOW(1)) u_b (
      .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Enable(i_Enable),
      .o_HSync(b_hs), .o_VSync(b_vs), .o_HSync_Pin(b_hp), .o_VSync_Pin(b_vp),
      .o_Col_Count(b_col), .o_Row_Count(b_row), .o_Active(b_act),
      .o_Line_Start(b_ls), .o_Frame_Start(b_fs), .o_Running(b_run));

   // ---------------- clock / reset ----------------
   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   // ---------------- reference model ----------------
   // Position in frame as a single pixel index; running flag; and whether
   // enable was low at the previous counting edge (a stop is pending).
   bit m_run  [2] = '{1'b0, 1'b0};
   bit m_stop [2] = '{1'b0, 1'b0};
   int m_p    [2] = '{0, 0};

   task automatic model_step(int d, bit en, bit rst);
      int period;
      period = P_TC[d] * P_TR[d];
      if (rst) begin
         m_run[d] = 1'b0; m_stop[d] = 1'b0; m_p[d] = 0;
      end else if (!m_run[d]) begin
         if (en) begin m_run[d] = 1'b1; m_stop[d] = 1'b0; m_p[d] = 0; end
      end else if (m_p[d] == period - 1 && m_stop[d] && !en) begin
         m_run[d] = 1'b0; m_stop[d] = 1'b0; m_p[d] = 0;
      end else begin
         m_p[d]    = (m_p[d] + 1) % period;
         m_stop[d] = !en;
      end
   endtask

   function automatic logic [27:0] model_out(int d);
      int c, r, hs0, hs1, vs0, vs1;
      logic idle_pin, hs, vs, hp, vp;
      idle_pin = (P_SAL[d] != 0);
      if (!m_run[d]) return {10'd0, 10'd0, 1'b0, 1'b0, idle_pin, idle_pin, 4'b0000};
      c   = m_p[d] % P_TC[d];
      r   = m_p[d] / P_TC[d];
      hs0 = P_AC[d] + P_HFP[d]; hs1 = hs0 + P_HSW[d];
      vs0 = P_AR[d] + P_VFP[d]; vs1 = vs0 + P_VSW[d];
      hs  = (c < P_AC[d]);
      vs  = (r < P_AR[d]);
      hp  = (c >= hs0 && c < hs1) ? !idle_pin : idle_pin;
      vp  = (r >= vs0 && r < vs1) ? !idle_pin : idle_pin;
      return {10'(c), 10'(r), hs, vs, hp, vp, hs && vs, (c == 0), (m_p[d] == 0), 1'b1};
   endfunction

   // ---------------- scoreboard ----------------
   logic [55:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   task automatic check(string name, logic [27:0] got, logic [27:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got col=%0d row=%0d flags=%b, expected col=%0d row=%0d flags=%b",
                  name, $time, got[27:18], got[17:8], got[7:0],
                  exp[27:18], exp[17:8], exp[7:0]);
      end
   endtask

   // Monitor: after every edge the DUTs present a fresh sample; pop and compare.
   initial begin
      logic [55:0] e;
      wait (mon_en);
      forever begin
         @(posedge i_Clk);
         #1;
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL queue_empty @%0t: got 0 entries, expected 1", $time);
         end else begin
            e = exp_q.pop_front();
            check("dut_a", act_a, e[55:28]);
            check("dut_b", act_b, e[27:0]);
         end
      end
   end

   // ---------------- driver ----------------
   // One call per cycle: drive inputs at the falling edge, advance the model
   // and queue what the next rising edge must show. A fresh reset assertion
   // is applied mid-cycle and checked immediately, before any clock edge.
   task automatic drive_cycle(bit en, bit rst);
      @(negedge i_Clk);
      if (rst && !i_Reset) begin
         i_Enable = en;
         #2 i_Reset = 1'b1;
         model_step(0, en, 1'b1);
         model_step(1, en, 1'b1);
         #1;
         check("async_rst_a", act_a, model_out(0));
         check("async_rst_b", act_b, model_out(1));
      end else begin
         i_Reset  = rst;
         i_Enable = en;
         model_step(0, en, rst);
         model_step(1, en, rst);
      end
      exp_q.push_back({model_out(0), model_out(1)});
      mon_en = 1'b1;
   endtask

   initial begin
      bit en;
      i_Reset  = 1'b1;
      i_Enable = 1'b0;
      #1;
      check("reset_a", act_a, model_out(0));
      check("reset_b", act_b, model_out(1));

      // Reset held with enable high, then release: frame starts on first edge.
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1);
      for (int i = 0; i < 700; i++) drive_cycle(1'b1, 1'b0);

      // Drop enable mid-frame: both instances drain to a frame boundary, then idle.
      for (int i = 0; i < 350; i++) drive_cycle(1'b0, 1'b0);

      // Slow random enable toggling: long runs, drains, and re-raises.
      en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 2) en = !en;
         drive_cycle(en, 1'b0);
      end

      // Mid-frame resets at random points.
      for (int k = 0; k < 10; k++) begin
         int run_len, rst_len;
         run_len = $urandom_range(50, 400);
         rst_len = $urandom_range(1, 3);
         for (int i = 0; i < run_len; i++) drive_cycle(1'b1, 1'b0);
         for (int i = 0; i < rst_len; i++) drive_cycle(1'($urandom_range(0, 1)), 1'b1);
      end

      // Fast random enable, every cycle.
      for (int i = 0; i < 500; i++) drive_cycle(1'($urandom_range(0, 1)), 1'b0);

      // Final drain to idle.
      for (int i = 0; i < 300; i++) drive_cycle(1'b0, 1'b0);

      @(posedge i_Clk);
      #2;
      if (exp_q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Free-running VGA timing source; the transmit end of the HSync/VSync interface that the video pipeline's sync-to-count stage consumes.
- Produces active-region sync pulses for downstream count recovery, plus true VGA pin syncs with porches and matching column/row counts.
- Enable/drain FSM so frames always stop on a frame boundary.
- Sits between the 25 MHz pixel clock and the game/render logic.

Parameters:
TOTAL_COLS, 800, pixels per line including blanking
TOTAL_ROWS, 525, lines per frame including blanking
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
H_FRONT_PORCH, 16, pixels from end of active to HS pin assertion
H_SYNC_WIDTH, 96, HS pin assertion length in pixels
V_FRONT_PORCH, 10, lines from end of active to VS pin assertion
V_SYNC_WIDTH, 2, VS pin assertion length in lines
SYNC_ACTIVE_LOW, 1, 1 = pin syncs asserted low, 0 = asserted high

Ports:
i_Clk  in  1  pixel clock
i_Reset  in  1  asynchronous, active-high reset
i_Enable  in  1  run request
o_HSync  out  1  active-region line pulse: high while col < ACTIVE_COLS
o_VSync  out  1  active-region frame pulse: high while row < ACTIVE_ROWS
o_HSync_Pin  out  1  VGA connector HS, with porches, polarity per SYNC_ACTIVE_LOW
o_VSync_Pin  out  1  VGA connector VS, with porches, polarity per SYNC_ACTIVE_LOW
o_Col_Count  out  10  current column, 0..TOTAL_COLS-1
o_Row_Count  out  10  current row, 0..TOTAL_ROWS-1
o_Active  out  1  o_HSync & o_VSync
o_Line_Start  out  1  one-cycle pulse when col == 0 while running
o_Frame_Start  out  1  one-cycle pulse when col == 0 and row == 0 while running
o_Running  out  1  high in RUN or DRAIN

Behaviour:
- Reset (async, active-high):
  - state IDLE; counts 0.
  - o_HSync, o_VSync, o_Active, o_Line_Start, o_Frame_Start, o_Running = 0.
  - Pins deasserted: 1 if SYNC_ACTIVE_LOW, else 0.
- All outputs are registers updated on the same edge. While o_Running, they are mutually consistent with the output counts, with zero lag.
- Counting in RUN/DRAIN, every edge:
  - col+1; at TOTAL_COLS-1, col wraps to 0 and row+1.
  - At row TOTAL_ROWS-1 with col TOTAL_COLS-1, both wrap to 0.
  - Frame period = TOTAL_COLS*TOTAL_ROWS cycles (420000 at defaults).
- HS pin asserted iff ACTIVE_COLS+H_FRONT_PORCH <= col < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH.
- VS pin asserted iff ACTIVE_ROWS+V_FRONT_PORCH <= row < ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH. The decision is by row only, so VS changes on col == 0 edges.
- FSM:
  - IDLE: counts held at 0, all outputs at reset values.
    - i_Enable=1 -> RUN. On that edge outputs show col 0, row 0: o_HSync=o_VSync=o_Active=1, o_Line_Start=o_Frame_Start=1, o_Running=1.
  - RUN: counting. i_Enable=0 -> DRAIN; counting is not disturbed.
  - DRAIN: counting continues.
    - i_Enable=1 -> RUN, with no glitch in counts or syncs.
    - At final pixel (TOTAL_COLS-1, TOTAL_ROWS-1):
      - i_Enable=0 -> IDLE; next edge shows reset-value outputs.
      - i_Enable=1 -> RUN; normal wrap with o_Frame_Start.
- Downstream sync-to-count sees a rising o_VSync exactly coincident with o_Frame_Start.
- Elaboration-time check (error if false):
  - ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH <= TOTAL_COLS
  - ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH <= TOTAL_ROWS
  - TOTAL_COLS, TOTAL_ROWS <= 1024
- Reset mid-frame: immediate return to IDLE/reset values. After release, a new frame starts from (0,0) only when i_Enable=1 is sampled.

Test Plan:
- Reset release with i_Enable=1 -> first edge: Col=0, Row=0, o_Frame_Start=1, o_HSync=1. o_HSync falls when Col=640; Line_Start recurs every 800 cycles.
- Defaults, one line -> HS pin low exactly for Col 656..751 (96 cycles), high elsewhere. o_HSync high for Col 0..639 only.
- Full frame -> VS pin low for Row 490..491 (1600 cycles). o_VSync high for Row 0..479. o_Frame_Start period 420000 cycles.
- Drop i_Enable at Row 100 -> counting continues through (799,524), then IDLE: Col=Row=0, o_Running=0, pins high, no further Frame_Start.
- Drop i_Enable at Row 100, re-raise at Row 200 -> no gap: Frame_Start at cycle 420000 as usual, o_Running stays 1.
- Assert i_Reset at Col 300, Row 50 with i_Enable high -> outputs reset asynchronously. After release, Col=0, Row=0 with Frame_Start=1 on the first edge.
- SYNC_ACTIVE_LOW=0, small params (TOTAL 10x8, ACTIVE 6x4, FP 1/1, SW 2/1) -> HS pin high for Col 7..8, VS pin high for Row 5, period 80 cycles.
